ofifo_drain: RTL

//  Consumer end of the corelet output FIFO (ofifo): on a start pulse, pops a

---
 rtl/ofifo_drain.sv | 120 ++++++++++++
 1 files changed

// File: rtl/ofifo_drain.sv
// ============================================================================
// ofifo_drain : pops a programmed number of psum vectors from the corelet ofifo
//               and writes them to the psum SRAM at consecutive addresses.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ofifo_drain #(
  parameter int COL     = 8,
  parameter int PSUM_BW = 16,
  parameter int ADDR_W  = 11,
  parameter int CNT_W   = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [CNT_W-1:0]       num_vec,
  input  logic                   ofifo_valid,
  input  logic [COL*PSUM_BW-1:0] ofifo_out,
  output logic                   ofifo_rd,
  output logic                   sram_cen,
  output logic                   sram_wen,
  output logic [ADDR_W-1:0]      sram_a,
  output logic [COL*PSUM_BW-1:0] sram_d,
  output logic                   busy,
  output logic                   done
);

  localparam int DW = COL * PSUM_BW;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              wr_pend_q, wr_pend_d;
  logic [ADDR_W-1:0] a_hold_q, a_hold_d;
  logic [DW-1:0]     d_hold_q, d_hold_d;

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    issued_d  = issued_q;
    ptr_d     = ptr_q;
    a_hold_d  = a_hold_q;
    d_hold_d  = d_hold_q;
    ofifo_rd  = 1'b0;
    done      = 1'b0;

    // Data popped last cycle is on ofifo_out now; write it and advance the
    // address pointer, which wraps naturally at 2^ADDR_W.
    if (wr_pend_q) begin
      ptr_d    = ptr_q + ADDR_W'(1);
      a_hold_d = ptr_q;
      d_hold_d = ofifo_out;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d    = num_vec;
          issued_d = '0;
          ptr_d    = base_addr;
          state_d  = (num_vec == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        if (ofifo_valid && (issued_q < num_q)) begin
          ofifo_rd = 1'b1;
          issued_d = issued_q + CNT_W'(1);
          if (issued_d == num_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    wr_pend_d = ofifo_rd;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      num_q     <= '0;
      issued_q  <= '0;
      ptr_q     <= '0;
      wr_pend_q <= 1'b0;
      a_hold_q  <= '0;
      d_hold_q  <= '0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      issued_q  <= issued_d;
      ptr_q     <= ptr_d;
      wr_pend_q <= wr_pend_d;
      a_hold_q  <= a_hold_d;
      d_hold_q  <= d_hold_d;
    end
  end

  assign sram_cen = ~wr_pend_q;
  assign sram_wen = ~wr_pend_q;
  assign sram_a   = wr_pend_q ? ptr_q : a_hold_q;
  assign sram_d   = wr_pend_q ? ofifo_out : d_hold_q;
  assign busy     = (state_q != S_IDLE);

endmodule

`default_nettype wire
